bcpu_flags_bank: RTL and testbench
==================================

// Module: bcpu_flags_bank
// PURPOSE
//  Per-thread {V,S,Z,C} flags storage for the BCPU16 barrel pipeline. ALU writeback updates the
//  flags of one thread per cycle under a bit mask; the read port delivers one thread's flags per
//  cycle, registered, to the branch condition evaluator's FLAGS_IN. A same-cycle write to the
//  thread being read is bypassed into the read result. The block is the stage directly upstream
//  of condition evaluation.
// PARAMETERS
//  THREAD_BITS  2        log2 of hardware thread count (2^THREAD_BITS flag registers)
//  RESET_FLAGS  4'b0000  value of every thread's flags and of FLAGS_OUT after reset, {V,S,Z,C}
// PORTS
//  CLK         in   1            clock, all state changes on rising edge
//  RESET       in   1            asynchronous reset, active-high
//  CE          in   1            pipeline advance; 0 = full stall, all state holds
//  RD_VALID    in   1            read request valid this cycle
//  RD_THREAD   in   THREAD_BITS  thread whose flags are read
//  WR_EN       in   1            flags writeback enable
//  WR_THREAD   in   THREAD_BITS  thread whose flags are written
//  WR_MASK     in   4            per-bit update mask {V,S,Z,C}; 1 = take WR_FLAGS bit
//  WR_FLAGS    in   4            new flag values {V,S,Z,C}
//  FLAGS_OUT   out  4            registered flags of THREAD_OUT, {V,S,Z,C}
//  THREAD_OUT  out  THREAD_BITS  thread id matching FLAGS_OUT
//  VALID_OUT   out  1            FLAGS_OUT/THREAD_OUT carry a valid read result
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): all bank entries = RESET_FLAGS,
//    FLAGS_OUT = RESET_FLAGS, THREAD_OUT = 0, VALID_OUT = 0. Pending write/read in that cycle lost.
//  - Storage: 2^THREAD_BITS x 4-bit registers, no RAM inference required.
//  - Merge function: M = (bank[WR_THREAD] & ~WR_MASK) | (WR_FLAGS & WR_MASK).
//  - Write: on rising edge with CE=1 and WR_EN=1, bank[WR_THREAD] <= M. WR_MASK=0 is a no-op.
//    CE=0 ignores the write (writer must hold the request through the stall).
//  - Read latency 1 cycle: on rising edge with CE=1:
//      VALID_OUT <= RD_VALID; if RD_VALID: THREAD_OUT <= RD_THREAD and
//      FLAGS_OUT <= (WR_EN && WR_THREAD==RD_THREAD) ? M : bank[RD_THREAD]  (write-through bypass).
//    RD_VALID=0: FLAGS_OUT and THREAD_OUT hold, VALID_OUT goes 0.
//  - CE=0: FLAGS_OUT, THREAD_OUT, VALID_OUT and bank all hold their values.
//  - Write to thread A and read of thread B!=A same cycle: independent; read returns old bank[B].
//  - No combinational path from inputs to outputs; outputs are flop outputs only.
//  - Thread ids are full-range; no out-of-range case exists.
// TESTING
//  1 Reset: RESET_FLAGS=4'b0000, pulse RESET mid-run after writes -> all outputs 0 immediately
//    (async), subsequent read of every thread returns 4'b0000.
//  2 Masked write: WR thread 2, MASK=4'b1111, FLAGS=4'b1010; next cycle WR thread 2, MASK=4'b0011,
//    FLAGS=4'b0101; then read thread 2 -> FLAGS_OUT=4'b1001, THREAD_OUT=2, VALID_OUT=1 one cycle later.
//  3 Bypass: bank[1]=4'b0000; same cycle WR thread 1 MASK=4'b0010 FLAGS=4'b0010 and RD thread 1
//    -> FLAGS_OUT=4'b0010 on next edge; non-matching read (thread 0) same cycle returns 4'b0000.
//  4 Stall: CE=0 for 3 cycles with WR_EN=1, RD_VALID=1 -> outputs and bank unchanged; raising CE
//    performs the write and read exactly once.
//  5 Barrel sweep: RD_THREAD cycling 0,1,2,3 every cycle with writeback to thread (rd-2) mod 4
//    of distinct values -> each FLAGS_OUT matches a reference model of per-thread flags.
//  6 RD_VALID=0 cycle between reads -> VALID_OUT=0 that cycle, FLAGS_OUT/THREAD_OUT hold.

Source files
------------

// File: rtl/bcpu_flags_bank.sv
// ---------------------------------------------------------------------------
// bcpu_flags_bank
//
// Per-thread {V,S,Z,C} condition flag storage for the BCPU16 barrel pipeline.
// The ALU writeback stage updates one thread's flags per cycle under a bit
// mask. The read port hands one thread's flags per cycle, registered, to the
// branch condition evaluator. A write that lands in the same cycle as a read
// of the same thread is forwarded into the read result, so the evaluator
// never sees stale flags.
//
// Parameters
//   THREAD_BITS  log2 of the hardware thread count
//   RESET_FLAGS  value of every thread's flags and of flags_out after reset
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous reset, active-high
//   ce          pipeline advance; 0 freezes every register in the block
//   rd_valid    read request valid this cycle
//   rd_thread   thread whose flags are read
//   wr_en       flags writeback enable
//   wr_thread   thread whose flags are written
//   wr_mask     per-bit update mask {V,S,Z,C}; 1 = take the wr_flags bit
//   wr_flags    new flag values {V,S,Z,C}
//   flags_out   registered flags of thread_out, {V,S,Z,C}
//   thread_out  thread id matching flags_out
//   valid_out   flags_out/thread_out carry a valid read result
// ---------------------------------------------------------------------------
module bcpu_flags_bank #(
  parameter int         THREAD_BITS = 2,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   rd_valid,
  input  logic [THREAD_BITS-1:0] rd_thread,
  input  logic                   wr_en,
  input  logic [THREAD_BITS-1:0] wr_thread,
  input  logic [3:0]             wr_mask,
  input  logic [3:0]             wr_flags,
  output logic [3:0]             flags_out,
  output logic [THREAD_BITS-1:0] thread_out,
  output logic                   valid_out
);

  localparam int THREADS = 1 << THREAD_BITS;

  // One 4-bit flag register per hardware thread.
  logic [3:0] bank [THREADS];

  logic [3:0] merged;
  logic       bypass;
  logic [3:0] rd_data;

  // Masked merge of the incoming writeback into the target thread's current
  // flags. A zero mask reproduces the stored value, so it is a harmless no-op.
  assign merged = (bank[wr_thread] & ~wr_mask) | (wr_flags & wr_mask);

  // Write-through: when the thread being read is also being written this
  // cycle, the reader gets the post-write value rather than the stale entry.
  assign bypass  = wr_en && (wr_thread == rd_thread);
  assign rd_data = bypass ? merged : bank[rd_thread];

  // Flag storage. A stall (ce=0) drops the write; the writer is expected to
  // hold its request until the pipeline advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < THREADS; i++) begin
        bank[i] <= RESET_FLAGS;
      end
    end else if (ce && wr_en) begin
      bank[wr_thread] <= merged;
    end
  end

  // Registered read port. Data and thread id only move on a valid read, so an
  // idle cycle keeps the last result visible while valid_out drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_out  <= RESET_FLAGS;
      thread_out <= '0;
      valid_out  <= 1'b0;
    end else if (ce) begin
      valid_out <= rd_valid;
      if (rd_valid) begin
        flags_out  <= rd_data;
        thread_out <= rd_thread;
      end
    end
  end

endmodule

// File: tb/tb_bcpu_flags_bank.sv
// ---------------------------------------------------------------------------
// tb_bcpu_flags_bank
//
// Directed bench for bcpu_flags_bank with THREAD_BITS=2, RESET_FLAGS=0.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_bcpu_flags_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       rd_valid;
  logic [1:0] rd_thread;
  logic       wr_en;
  logic [1:0] wr_thread;
  logic [3:0] wr_mask;
  logic [3:0] wr_flags;
  logic [3:0] flags_out;
  logic [1:0] thread_out;
  logic       valid_out;

  int errors = 0;
  int checks = 0;

  // Reference copy of the per-thread flags, used by the barrel sweep.
  logic [3:0] model [4];

  bcpu_flags_bank #(
    .THREAD_BITS(2),
    .RESET_FLAGS(4'b0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .rd_valid  (rd_valid),
    .rd_thread (rd_thread),
    .wr_en     (wr_en),
    .wr_thread (wr_thread),
    .wr_mask   (wr_mask),
    .wr_flags  (wr_flags),
    .flags_out (flags_out),
    .thread_out(thread_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's worth of inputs.
  task automatic apply_stimulus(input logic c, input logic rv, input logic [1:0] rt,
                                input logic we, input logic [1:0] wt,
                                input logic [3:0] m, input logic [3:0] f);
    ce        = c;
    rd_valid  = rv;
    rd_thread = rt;
    wr_en     = we;
    wr_thread = wt;
    wr_mask   = m;
    wr_flags  = f;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check all three read-port outputs at once.
  task automatic check_read(input string tag, input logic [3:0] f,
                            input logic [1:0] t, input logic v);
    check_output({tag, "_flags"}, {4'b0, flags_out}, {4'b0, f});
    check_output({tag, "_thread"}, {6'b0, thread_out}, {6'b0, t});
    check_output({tag, "_valid"}, {7'b0, valid_out}, {7'b0, v});
  endtask

  initial begin
    logic [3:0] masks [8];
    logic [3:0] flags [8];
    logic [3:0] exp_flags;
    logic [1:0] rt;
    logic [1:0] wt;

    masks = '{4'b1111, 4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0110};
    flags = '{4'b0011, 4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b1001, 4'b0110, 4'b1100};

    $display("[TB] start");
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick();
    tick();
    check_read("reset_state", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;

    // Masked write: full write then partial overwrite of thread 2.
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b1111, 4'b1010);
    tick();
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0011, 4'b0101);
    tick();
    apply_stimulus(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick();
    check_read("masked_rd2", 4'b1001, 2'd2, 1'b1);

    // Idle read slot: valid drops, data and thread hold.
    apply_stimulus(1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick();
    check_read("idle_hold", 4'b1001, 2'd2, 1'b0);

    // Bypass on a matching read.
    apply_stimulus(1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010, 4'b0010);
    tick();
    check_read("bypass_rd1", 4'b0010, 2'd1, 1'b1);

    // Write thread 1 while reading thread 0: independent, old value returned.
    apply_stimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'b0100, 4'b0100);
    tick();
    check_read("nomatch_rd0", 4'b0000, 2'd0, 1'b1);

    // Zero mask is a no-op, seen through the bypass path.
    apply_stimulus(1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0000, 4'b1111);
    tick();
    check_read("zero_mask_rd1", 4'b0110, 2'd1, 1'b1);

    // Stall for three cycles with a write and read pending.
    apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1, 2'd3, 4'b1111, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_read("stall_hold", 4'b0110, 2'd1, 1'b1);
    end
    ce = 1'b1;
    tick();
    check_read("stall_release", 4'b1101, 2'd3, 1'b1);
    apply_stimulus(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick();
    check_read("post_stall_rd3", 4'b1101, 2'd3, 1'b1);

    // Barrel sweep with writeback two threads behind the reader.
    model[0] = 4'b0000;
    model[1] = 4'b0110;
    model[2] = 4'b1001;
    model[3] = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      rt = 2'(i % 4);
      wt = 2'((i + 2) % 4);
      apply_stimulus(1'b1, 1'b1, rt, 1'b1, wt, masks[i], flags[i]);
      exp_flags = model[rt];
      tick();
      check_read("sweep", exp_flags, rt, 1'b1);
      model[wt] = (model[wt] & ~masks[i]) | (flags[i] & masks[i]);
    end
    for (int i = 0; i < 4; i++) begin
      rt = 2'(i);
      apply_stimulus(1'b1, 1'b1, rt, 1'b0, 2'd0, 4'b0000, 4'b0000);
      tick();
      check_read("sweep_final", model[rt], rt, 1'b1);
    end

    // Asynchronous reset mid-cycle with a write pending.
    apply_stimulus(1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 4'b1111, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    check_read("async_reset", 4'b0000, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rt = 2'(i);
      apply_stimulus(1'b1, 1'b1, rt, 1'b0, 2'd0, 4'b0000, 4'b0000);
      tick();
      check_read("post_reset_rd", 4'b0000, rt, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
